// File: rtl/toggle_event_receiver_pkg.sv
// ============================================================================
// Module      : toggle_event_receiver_pkg
// Description : Counter-action encoding and decode helper for the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toggle_event_receiver_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2,
        ACT_SAT  = 2'd3
    } cnt_act_e;

    // A simultaneous arrival and consumption cancel out in the count.
    function automatic cnt_act_e cnt_action(input logic inc, input logic take,
                                            input logic full);
        if (inc && !take) begin
            return full ? ACT_SAT : ACT_INC;
        end else if (!inc && take) begin
            return ACT_DEC;
        end
        return ACT_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tog_sync.sv
// ============================================================================
// Module      : tog_sync
// Description : Multi-flop synchroniser for an asynchronous level input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tog_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/toggle_link_defs.vh
// Default link parameters shared by the toggle-event sender and receiver.
`ifndef TOGGLE_LINK_DEFS_VH
`define TOGGLE_LINK_DEFS_VH

`define TOGGLE_LINK_SYNC_STAGES 2
`define TOGGLE_LINK_CNT_W       4

`endif

// File: rtl/toggle_event_receiver.sv
// ============================================================================
// Module      : toggle_event_receiver
// Description : Turns tog_in transitions into queued events drained by
//               valid/ready; each consumed event toggles tog_ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`include "toggle_link_defs.vh"

module toggle_event_receiver
    import toggle_event_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = `TOGGLE_LINK_SYNC_STAGES,
    parameter int CNT_W       = `TOGGLE_LINK_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_count,
    output logic             pulse_out,
    output logic             ovf,
    output logic             tog_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s_last;
    logic             prev_q,  prev_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic             ack_q,   ack_d;
    logic             take;
    cnt_act_e         act;

    tog_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tog_in),
        .q     (s_last)
    );

    always_comb begin
        prev_d  = s_last;
        pulse_d = s_last ^ prev_q;
        take    = (cnt_q != '0) & evt_ready;
        act     = cnt_action(pulse_q, take, cnt_q == CNT_MAX);
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ack_d   = ack_q ^ take;
        // Clear wins over any arrival or consumption in the same cycle.
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            case (act)
                ACT_INC: cnt_d = cnt_q + CNT_ONE;
                ACT_DEC: cnt_d = cnt_q - CNT_ONE;
                ACT_SAT: ovf_d = 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
        end
    end

    assign evt_valid = (cnt_q != '0);
    assign evt_count = cnt_q;
    assign pulse_out = pulse_q;
    assign ovf       = ovf_q;
    assign tog_ack   = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_toggle_event_receiver.sv
// ============================================================================
// Module      : tb_toggle_event_receiver
// Description : Scoreboard bench for toggle_event_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_toggle_event_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             tog_in    = 1'b0;
    logic             clr       = 1'b0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [CNT_W-1:0] evt_count;
    logic             pulse_out;
    logic             ovf;
    logic             tog_ack;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int sbq[$];
    int ack_flips = 0;
    int max_cnt   = 0;
    logic ack_prev = 1'b0;
    logic ack_save;

    toggle_event_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_count (evt_count),
        .pulse_out (pulse_out),
        .ovf       (ovf),
        .tog_ack   (tog_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every pulse must match the oldest expected arrival cycle in the scoreboard.
    always @(negedge clk) begin
        if (pulse_out === 1'b1) begin
            if (sbq.size() == 0) check_val("pulse_unexpected", 1, 0);
            else                 check_val("pulse_latency", cyc, sbq.pop_front());
        end
        if (tog_ack !== ack_prev) ack_flips++;
        ack_prev = tog_ack;
        if (int'(evt_count) > max_cnt) max_cnt = int'(evt_count);
    end

    task automatic do_toggle();
        @(posedge clk);
        #2;
        tog_in = ~tog_in;
        sbq.push_back(cyc + 1 + SYNC_STAGES);
        @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and quiet period
        repeat (3) @(negedge clk);
        check_val("rst_outputs", {evt_valid, evt_count, pulse_out, ovf, tog_ack}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("idle_outputs", {evt_valid, evt_count, pulse_out, ovf, tog_ack}, 0);
        end

        // Single rising toggle
        do_toggle();
        repeat (SYNC_STAGES + 3) @(negedge clk);
        check_val("single_count", evt_count, 1);
        check_val("single_valid", evt_valid, 1);
        check_val("single_sb_empty", sbq.size(), 0);

        // Four queued events drained one per cycle
        pulse_clr();
        check_val("clr_count", evt_count, 0);
        for (int i = 0; i < 4; i++) do_toggle();
        repeat (6) @(negedge clk);
        check_val("queued_count", evt_count, 4);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("drain_count", evt_count, 3 - i);
            check_val("drain_ack", tog_ack, (i % 2 == 0) ? 1 : 0);
        end
        evt_ready = 1'b0;
        check_val("drain_valid", evt_valid, 0);

        // Continuous consumption: count never exceeds 1
        @(negedge clk);
        ack_flips = 0;
        max_cnt   = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) do_toggle();
        repeat (6) @(negedge clk);
        evt_ready = 1'b0;
        check_val("osc_max", max_cnt, 1);
        check_val("osc_flips", ack_flips, 6);
        check_val("osc_count", evt_count, 0);

        // Saturation and overflow, then clear
        for (int i = 0; i < 16; i++) do_toggle();
        repeat (6) @(negedge clk);
        check_val("sat_count", evt_count, 15);
        check_val("sat_ovf", ovf, 1);
        ack_save = tog_ack;
        pulse_clr();
        check_val("clr2_count", evt_count, 0);
        check_val("clr2_ovf", ovf, 0);
        check_val("clr2_ack", tog_ack, ack_save);

        // Ready with nothing pending must not acknowledge
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        evt_ready = 1'b0;
        check_val("idle_ready_ack", tog_ack, ack_save);

        // Asynchronous reset mid-operation, tog_in high at release
        for (int i = 0; i < 3; i++) do_toggle();
        repeat (6) @(negedge clk);
        check_val("pre_rst_count", evt_count, 3);
        check_val("pre_rst_sb_empty", sbq.size(), 0);
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        tog_in = 1'b1;
        #1;
        check_val("async_rst_outputs", {evt_valid, evt_count, pulse_out, ovf, tog_ack}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back(cyc + 3);
        repeat (3) @(negedge clk);
        check_val("post_rst_count_early", evt_count, 0);
        @(negedge clk);
        check_val("post_rst_count", evt_count, 1);
        check_val("post_rst_sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
